bcd_scan_counter: RTL and testbench
===================================

Name: bcd_scan_counter

Overview:
- Parametrised N-digit BCD counter with a built-in prescaler and a time-multiplexed, active-low 7-segment display driver.
- Successor to the fixed 3-digit auto counter. Adds:
  - a configurable digit count and configurable divider ratios;
  - count enable and synchronous clear;
  - a wrap strobe and leading-zero blanking;
  - an optional down-count mode.
- Sits between the board clock and the anode/segment pins of the Spartan-3E display.

Parameters:
- NDIG, 4, number of BCD digits (1..8).
- TICK_DIV, 4000000, clk cycles per count step (>=2).
- SCAN_DIV, 50000, clk cycles per displayed digit slot (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- en  in  1  count enable, sampled on tick cycles.
- clr  in  1  synchronous clear of count value.
- dir  in  1  count direction, 0=up, 1=down; used only with UPDOWN_EN.
- blank_lz  in  1  1 = blank leading zero digits.
- count_bcd  out  4*NDIG  current value; digit i at bits [4i+3:4i]; digit 0 = least significant.
- wrap  out  1  one-cycle pulse when count rolls over.
- an  out  NDIG  digit anodes, active-low, one-hot-low or all ones.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low; dp always 1.

Behaviour:
- Reset (rst=0 at clk edge) clears all of the following:
  - count_bcd=0, wrap=0, an=all ones, seg=8'hFF;
  - prescaler=0, scan counter=0, scan index=0.
  - rst has priority over every other input.
- Prescaler:
  - free-running counter 0..TICK_DIV-1, width clog2(TICK_DIV).
  - Internal tick is high for the single cycle in which the counter equals TICK_DIV-1; the counter returns to 0 on the next edge.
  - Prescaler runs regardless of en.
- Count update priority is clr, then tick&en.
  - clr=1: count_bcd<=0 on the next edge, wrap=0, prescaler is not reset.
  - tick&en up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - All digits at 9 -> all 0, and wrap=1 for exactly that one cycle.
  - tick&~en: value holds, wrap=0.
- Digit values are never outside 0..9 when the block is driven only through its ports.
- Scan:
  - scan counter runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the scan index advances 0,1,..,NDIG-1, then wraps to 0.
- Blanking: digit i (i>=1) is blanked when blank_lz=1 and digits NDIG-1..i are all 0. Digit 0 is never blanked.
- Outputs are registered and update every cycle from the current index and count. Latency from a count or index change to an/seg is 1 cycle.
  - Digit not blanked: an=~(1<<idx) and seg is the decoded digit.
  - Digit blanked: an=all ones and seg=8'hFF.
- Decode table (seg hex) for digits 0..9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - Any other nibble decodes to seg=8'hFF, for defensive coverage.
- If en changes in a non-tick cycle, there is no effect.
- If clr and tick coincide, clr wins and the tick is lost.

Optional Feature:
- Macro UPDOWN_EN.
- Defined: dir=1 on tick&en decrements digit 0 and borrows into the next digit (a digit at 0 goes to 9). All digits 0 -> all 9, with wrap=1 for one cycle. dir=0 counts up as above.
- Not defined: dir is ignored and the block counts up only. Port list is identical in both builds.

Test Plan:
All scenarios use NDIG=3, TICK_DIV=4, SCAN_DIV=2.
- Reset: hold rst=0 for 3 cycles with en=1 -> count_bcd=12'h000, an=3'b111, seg=8'hFF, wrap=0. Release rst -> first count step occurs exactly 4 cycles later.
- Carry chain: en=1, run 100 ticks from 0 -> count_bcd=12'h100. Count step 9->10 is observed as 12'h009 -> 12'h010.
- Rollover: preload to 999 by counting, then 1 more tick -> count_bcd=12'h000 and wrap high for exactly 1 cycle. No wrap on any other step.
- Scan/blank with value 12'h007:
  - blank_lz=1 -> an cycles 110,111,111, holding each for 2 cycles, and seg=F8 in the 110 slot.
  - blank_lz=0 -> an cycles 110,101,011 with seg F8,C0,C0.
- clr vs tick: assert clr on a tick cycle with en=1 at value 12'h045 -> next value 12'h000, not 12'h046. With en=0, ticks leave the value unchanged.
- UPDOWN_EN build, dir=1 from 12'h000:
  - 1 tick -> 12'h999 with wrap pulse.
  - Next tick -> 12'h998.
  - From 12'h100, 1 tick -> 12'h099.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// N-digit BCD counter with prescaler and multiplexed active-low 7-seg driver.
// Ports: clk, rst (sync, active-low), en, clr, dir, blank_lz in;
//        count_bcd[4*NDIG], wrap, an[NDIG], seg[8] out.
// Macro UPDOWN_EN enables down-counting via dir; otherwise dir is ignored.
module bcd_scan_counter #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 4000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              dir,
  input  logic              blank_lz,
  output logic [4*NDIG-1:0] count_bcd,
  output logic              wrap,
  output logic [NDIG-1:0]   an,
  output logic [7:0]        seg
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NDIG - 1);

  logic [TW-1:0]     pre_q, pre_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              tick, scan_last, down;

  `ifdef UPDOWN_EN
  assign down = dir;
  `else
  logic unused_dir;
  assign unused_dir = dir;
  assign down       = 1'b0;
  `endif

  function automatic logic [7:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 8'hC0;
      4'd1:    dec7 = 8'hF9;
      4'd2:    dec7 = 8'hA4;
      4'd3:    dec7 = 8'hB0;
      4'd4:    dec7 = 8'h99;
      4'd5:    dec7 = 8'h92;
      4'd6:    dec7 = 8'h82;
      4'd7:    dec7 = 8'hF8;
      4'd8:    dec7 = 8'h80;
      4'd9:    dec7 = 8'h90;
      default: dec7 = 8'hFF;
    endcase
  endfunction

  assign tick      = (pre_q == TICK_MAX);
  assign pre_d     = tick ? '0 : pre_q + 1'b1;
  assign scan_last = (scan_q == SCAN_MAX);
  assign scan_d    = scan_last ? '0 : scan_q + 1'b1;

  always_comb begin
    idx_d = idx_q;
    if (scan_last) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Ripple carry/borrow across digits; a carry out of the top digit is the wrap.
  always_comb begin
    logic       cy;
    logic [3:0] dig;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    cy     = 1'b0;
    dig    = '0;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && en) begin
      cy = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        dig = cnt_q[4*i +: 4];
        if (cy) begin
          if (down) begin
            if (dig == 4'd0) begin
              dig = 4'd9;
            end else begin
              dig = dig - 4'd1;
              cy  = 1'b0;
            end
          end else begin
            if (dig >= 4'd9) begin
              dig = 4'd0;
            end else begin
              dig = dig + 4'd1;
              cy  = 1'b0;
            end
          end
        end
        cnt_d[4*i +: 4] = dig;
      end
      wrap_d = cy;
    end
  end

  // Digit i is blanked when it and every digit above it are zero.
  always_comb begin
    logic            allz;
    logic [NDIG-1:0] blank;
    logic [3:0]      cur;
    logic            sel_blank;
    allz      = 1'b1;
    blank     = '0;
    cur       = '0;
    sel_blank = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      allz     = allz & (cnt_q[4*i +: 4] == 4'd0);
      blank[i] = blank_lz & allz;
    end
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur       = cnt_q[4*i +: 4];
        sel_blank = blank[i];
      end
    end
    an_d  = sel_blank ? '1 : ~(NDIG'(1) << idx_q);
    seg_d = sel_blank ? 8'hFF : dec7(cur);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q  <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      an_q   <= '1;
      seg_q  <= 8'hFF;
    end else begin
      pre_q  <= pre_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign count_bcd = cnt_q;
  assign wrap      = wrap_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed scoreboard bench for bcd_scan_counter (NDIG=3, TICK_DIV=4, SCAN_DIV=2).
// Down-count steps run when UPDOWN_EN is defined; otherwise dir must be ignored.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        dir = 1'b0;
  logic        blank_lz = 1'b0;
  logic [11:0] count_bcd;
  logic        wrap;
  logic [2:0]  an;
  logic [7:0]  seg;

  int n_chk = 0;
  int n_fail = 0;
  int wrap_cnt = 0;
  int tb_pre = 0;
  logic [31:0] exp_q[$];

  bcd_scan_counter #(
    .NDIG(3),
    .TICK_DIV(4),
    .SCAN_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr(clr),
    .dir(dir),
    .blank_lz(blank_lz),
    .count_bcd(count_bcd),
    .wrap(wrap),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  // Reference prescaler: tick cycle is the one where it reads 3.
  always @(posedge clk) begin
    if (!rst) tb_pre <= 0;
    else tb_pre <= (tb_pre == 3) ? 0 : tb_pre + 1;
  end

  always @(posedge clk) begin
    if (wrap === 1'b1) wrap_cnt <= wrap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      while (tb_pre != 3) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_clr();
    en  = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic scan_check(input string tag);
    logic [2:0] p;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      p = an;
      @(negedge clk);
      if (an == 3'b110 && p != 3'b110) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    for (int j = 0; j < 6; j++) begin
      pop_chk(tag, {21'd0, an, seg});
      if (j < 5) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count_bcd), 32'h000);
    chk("rst_an", 32'(an), 32'h7);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_wrap", 32'(wrap), 32'h0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_step", 32'(count_bcd), 32'h000);
    @(negedge clk);
    chk("first_step", 32'(count_bcd), 32'h001);

    push(32'h009);
    do_tick(8);
    pop_chk("carry_9", 32'(count_bcd));
    push(32'h010);
    do_tick(1);
    pop_chk("carry_10", 32'(count_bcd));
    push(32'h100);
    do_tick(90);
    pop_chk("carry_100", 32'(count_bcd));
    chk("no_wrap_early", 32'(wrap_cnt), 32'd0);

    push(32'h999);
    do_tick(899);
    pop_chk("pre_roll", 32'(count_bcd));
    chk("no_wrap_999", 32'(wrap_cnt), 32'd0);
    push(32'h000);
    do_tick(1);
    pop_chk("roll_zero", 32'(count_bcd));
    chk("wrap_hi", 32'(wrap), 32'h1);
    @(negedge clk);
    chk("wrap_lo", 32'(wrap), 32'h0);
    chk("wrap_once", 32'(wrap_cnt), 32'd1);

    do_clr();
    en = 1'b1;
    push(32'h007);
    do_tick(7);
    en = 1'b0;
    pop_chk("preload7", 32'(count_bcd));

    blank_lz = 1'b1;
    repeat (4) @(negedge clk);
    push({21'd0, 3'b110, 8'hF8});
    push({21'd0, 3'b110, 8'hF8});
    repeat (4) push({21'd0, 3'b111, 8'hFF});
    scan_check("scan_blank");

    blank_lz = 1'b0;
    repeat (4) @(negedge clk);
    push({21'd0, 3'b110, 8'hF8});
    push({21'd0, 3'b110, 8'hF8});
    push({21'd0, 3'b101, 8'hC0});
    push({21'd0, 3'b101, 8'hC0});
    push({21'd0, 3'b011, 8'hC0});
    push({21'd0, 3'b011, 8'hC0});
    scan_check("scan_full");

    do_clr();
    en = 1'b1;
    push(32'h045);
    do_tick(45);
    pop_chk("preload45", 32'(count_bcd));
    while (tb_pre != 3) @(negedge clk);
    clr = 1'b1;
    push(32'h000);
    @(negedge clk);
    clr = 1'b0;
    pop_chk("clr_wins", 32'(count_bcd));
    chk("clr_no_wrap", 32'(wrap), 32'h0);
    push(32'h002);
    do_tick(2);
    en = 1'b0;
    pop_chk("post_clr", 32'(count_bcd));
    push(32'h002);
    do_tick(3);
    pop_chk("en_hold", 32'(count_bcd));
    while (tb_pre != 1) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    push(32'h002);
    do_tick(1);
    pop_chk("en_nontick", 32'(count_bcd));
    chk("wrap_total", 32'(wrap_cnt), 32'd1);

`ifdef UPDOWN_EN
    do_clr();
    dir = 1'b1;
    en  = 1'b1;
    push(32'h999);
    do_tick(1);
    pop_chk("down_wrap", 32'(count_bcd));
    chk("down_wrap_hi", 32'(wrap), 32'h1);
    push(32'h998);
    do_tick(1);
    pop_chk("down_998", 32'(count_bcd));
    do_clr();
    dir = 1'b0;
    en  = 1'b1;
    push(32'h100);
    do_tick(100);
    pop_chk("up_100", 32'(count_bcd));
    dir = 1'b1;
    push(32'h099);
    do_tick(1);
    pop_chk("down_099", 32'(count_bcd));
    en = 1'b0;
`else
    do_clr();
    dir = 1'b1;
    en  = 1'b1;
    push(32'h001);
    do_tick(1);
    pop_chk("dir_ignored", 32'(count_bcd));
    chk("dir_no_wrap", 32'(wrap), 32'h0);
    en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
